wb_uart_msg_sequencer: RTL
==========================

Name: wb_uart_msg_sequencer

Overview:
- Wishbone master that drives the UART peripheral to transmit a parametrised N-character message.
- Sequence: baud config once, then per character: load TX buffer, start, poll done flag, clear flag; optional inter-message delay and repeat.
- Full ack/err/rty handshake, poll and ack timeouts, retry count, status/LED outputs.
- Replaces the fixed 3-character, no-handshake control unit at the top of the frequency-counter design.

Parameters:
- MSG_LEN, 3, characters per message (1..16).
- BAUD_WORD, 32'h40000000, value written to baud register.
- DELAY_CYCLES, 500000, idle cycles between repeated messages (>=1).
- POLL_TIMEOUT, 1024, status reads without done flag before error.
- ACK_TIMEOUT, 255, cycles waiting for ack/err/rty before the attempt counts as err.
- MAX_RETRY, 3, retries per bus transaction after err/rty/timeout.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle start pulse, sampled in IDLE only.
- repeat_i  in  1  1 = resend message after delay; sampled at end of DELAY.
- msg_i  in  8*MSG_LEN  message bytes, byte 0 = msg_i[7:0] sent first; sampled per character in LOAD_TX.
- addr_o  out  32  Wishbone address.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data.
- we_o  out  1  write enable.
- sel_o  out  4  byte select, constant 4'hF.
- cyc_o  out  1  bus cycle.
- stb_o  out  1  strobe.
- lock_o  out  1  constant 0.
- ack_i, err_i, rty_i  in  1 each  slave termination.
- tagn_i  in  1  unused.
- tagn_o  out  1  constant 0.
- busy_o  out  1  high outside IDLE/ERROR.
- done_o  out  1  one-cycle pulse after last CLEAR of each message.
- error_o  out  1  high in ERROR.
- char_idx_o  out  4  index of character in flight.
- out_led  out  10  {2'b00, last character loaded}.

Behaviour:
- Reset (async, rst_i=1): state IDLE; every output 0 except sel_o=4'hF; all counters 0. Reset mid-transaction drops cyc_o/stb_o immediately.
- Bus transaction: cyc_o=stb_o=1 with addr/dat/we held stable until a termination is sampled. ack_i -> transaction done, cyc_o/stb_o low next cycle; one idle cycle minimum between transactions. Same-cycle terminations: err_i beats rty_i beats ack_i. err_i, rty_i or ACK_TIMEOUT cycles without termination -> retry_cnt+1, reissue identical transaction after one idle cycle; retry_cnt > MAX_RETRY -> ERROR. retry_cnt clears on every ack.
- States (register map: ctrl 0x3, status 0x5, baud 0x4, TX 0x7):
  - IDLE: start_i -> CFG_BAUD, char_idx=0.
  - CFG_BAUD: write 0x4 <= BAUD_WORD -> LOAD_TX.
  - LOAD_TX: write 0x7 <= {24'b0, msg byte[char_idx]}; out_led updated on ack -> START_TX.
  - START_TX: write 0x3 <= 32'h80 -> POLL, poll_cnt=0.
  - POLL: read 0x5; on ack, dat_i[5]=1 -> CLEAR; else poll_cnt+1, reread; poll_cnt reaching POLL_TIMEOUT -> ERROR.
  - CLEAR: write 0x5 <= 0. On ack: char_idx<MSG_LEN-1 -> char_idx+1, LOAD_TX; else done_o pulse, char_idx=0 -> DELAY if repeat_i, else IDLE.
  - DELAY: bus idle, count DELAY_CYCLES cycles; at end repeat_i=1 -> LOAD_TX (baud not rewritten), else IDLE.
  - ERROR: bus idle, error_o=1; exit only via reset.
- start_i outside IDLE ignored. MSG_LEN=1: CLEAR always ends the message. char_idx never exceeds MSG_LEN-1.

Test Plan:
- MSG_LEN=3, msg_i=24'h555241, zero-wait ack slave, done flag set on 2nd poll, repeat_i=0 -> writes 0x4<=0x40000000, then per byte 0x7<=0x41/0x52/0x55, 0x3<=0x80, two reads of 0x5, 0x5<=0; one done_o pulse; returns IDLE; out_led=0x055.
- Same with repeat_i=1, DELAY_CYCLES=10 -> second message starts with 0x7<=0x41 exactly 10 idle cycles after first done_o; no second baud write.
- Slave asserts err_i on first LOAD_TX attempt, ack on second -> identical transaction reissued once, sequence completes, error_o=0.
- Slave never acks, ACK_TIMEOUT=4, MAX_RETRY=3 -> four attempts of 4 cycles each, then ERROR, error_o=1, cyc_o=0.
- Done flag never set, POLL_TIMEOUT=8 -> exactly 8 status reads, then ERROR.
- rst_i pulsed while stb_o=1 in POLL -> cyc_o/stb_o/busy_o drop same cycle; next start_i restarts at baud write.

Source files
------------

// File: rtl/wb_uart_msg_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : wb_uart_msg_sequencer_if
// Description : Wishbone bus bundle between the message sequencer (master)
//               and the UART register block (slave).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface wb_uart_msg_sequencer_if;
  logic [31:0] addr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        lock_o;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;
  logic        tagn_i;
  logic        tagn_o;

  modport master (
    output addr_o, dat_o, we_o, sel_o, cyc_o, stb_o, lock_o, tagn_o,
    input  dat_i, ack_i, err_i, rty_i, tagn_i
  );

  modport slave (
    input  addr_o, dat_o, we_o, sel_o, cyc_o, stb_o, lock_o, tagn_o,
    output dat_i, ack_i, err_i, rty_i, tagn_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_uart_msg_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : wb_uart_msg_sequencer
// Description : Wishbone master that programs the UART baud rate once and
//               then sends an N-character message byte by byte (load TX,
//               start, poll done flag, clear flag), with retry on err/rty/
//               ack timeout, poll timeout, and optional delayed repeat.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module wb_uart_msg_sequencer #(
  parameter int unsigned MSG_LEN      = 3,
  parameter logic [31:0] BAUD_WORD    = 32'h4000_0000,
  parameter int unsigned DELAY_CYCLES = 500000,
  parameter int unsigned POLL_TIMEOUT = 1024,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_i,
  input  wire logic                 start_i,
  input  wire logic                 repeat_i,
  input  wire logic [8*MSG_LEN-1:0] msg_i,
  wb_uart_msg_sequencer_if.master   wb,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [3:0]                char_idx_o,
  output logic [9:0]                out_led
);

  localparam int unsigned c_ack_w   = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
  localparam int unsigned c_poll_w  = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
  localparam int unsigned c_delay_w = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int unsigned c_retry_w = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [31:0] c_reg_ctrl   = 32'h3;
  localparam logic [31:0] c_reg_baud   = 32'h4;
  localparam logic [31:0] c_reg_status = 32'h5;
  localparam logic [31:0] c_reg_tx     = 32'h7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_BAUD = 3'd1,
    S_LOAD_TX  = 3'd2,
    S_START_TX = 3'd3,
    S_POLL     = 3'd4,
    S_CLEAR    = 3'd5,
    S_DELAY    = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  state_t                 r_state;
  logic                   r_cyc;
  logic                   r_stb;
  logic                   r_we;
  logic [31:0]            r_addr;
  logic [31:0]            r_dat;
  logic                   r_done;
  logic [3:0]             r_char_idx;
  logic [9:0]             r_led;
  logic [c_ack_w-1:0]     r_ack_cnt;
  logic [c_poll_w-1:0]    r_poll_cnt;
  logic [c_delay_w-1:0]   r_delay_cnt;
  logic [c_retry_w-1:0]   r_retry_cnt;

  logic [7:0]             w_byte;
  logic [31:0]            w_addr;
  logic [31:0]            w_dat;
  logic                   w_we;
  logic                   w_ack_to;
  logic                   w_fail;

  // Byte currently addressed by char_idx; byte 0 sits in the low bits.
  assign w_byte = 8'(msg_i >> {r_char_idx, 3'b000});

  // An attempt fails on err or rty (both beat a simultaneous ack), or when
  // the last allowed wait cycle passes without any termination.
  assign w_ack_to = (r_ack_cnt == c_ack_w'(ACK_TIMEOUT - 1));
  assign w_fail   = wb.err_i | wb.rty_i | (~wb.ack_i & w_ack_to);

  // Register-access description of the transaction owned by each bus state.
  always_comb begin
    w_addr = '0;
    w_dat  = '0;
    w_we   = 1'b0;
    case (r_state)
      S_CFG_BAUD: begin w_addr = c_reg_baud;   w_dat = BAUD_WORD;        w_we = 1'b1; end
      S_LOAD_TX:  begin w_addr = c_reg_tx;     w_dat = {24'b0, w_byte};  w_we = 1'b1; end
      S_START_TX: begin w_addr = c_reg_ctrl;   w_dat = 32'h0000_0080;    w_we = 1'b1; end
      S_POLL:     begin w_addr = c_reg_status; w_dat = '0;               w_we = 1'b0; end
      S_CLEAR:    begin w_addr = c_reg_status; w_dat = '0;               w_we = 1'b1; end
      default:    ;
    endcase
  end

  // Sequencer: each bus state idles one cycle with cyc low, issues its
  // transaction, then holds it until a termination or ack timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_done      <= 1'b0;
      r_char_idx  <= '0;
      r_led       <= '0;
      r_ack_cnt   <= '0;
      r_poll_cnt  <= '0;
      r_delay_cnt <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state    <= S_CFG_BAUD;
            r_char_idx <= '0;
          end
        end
        S_CFG_BAUD, S_LOAD_TX, S_START_TX, S_POLL, S_CLEAR: begin
          if (!r_cyc) begin
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_addr    <= w_addr;
            r_dat     <= w_dat;
            r_we      <= w_we;
            r_ack_cnt <= '0;
          end else if (w_fail) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_retry_cnt == c_retry_w'(MAX_RETRY)) begin
              r_state <= S_ERROR;
            end else begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end
          end else if (wb.ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_retry_cnt <= '0;
            case (r_state)
              S_CFG_BAUD: r_state <= S_LOAD_TX;
              S_LOAD_TX: begin
                r_led   <= {2'b00, r_dat[7:0]};
                r_state <= S_START_TX;
              end
              S_START_TX: begin
                r_poll_cnt <= '0;
                r_state    <= S_POLL;
              end
              S_POLL: begin
                if (wb.dat_i[5]) begin
                  r_state <= S_CLEAR;
                end else if (r_poll_cnt == c_poll_w'(POLL_TIMEOUT - 1)) begin
                  r_state <= S_ERROR;
                end else begin
                  r_poll_cnt <= r_poll_cnt + 1'b1;
                end
              end
              S_CLEAR: begin
                if (r_char_idx != 4'(MSG_LEN - 1)) begin
                  r_char_idx <= r_char_idx + 1'b1;
                  r_state    <= S_LOAD_TX;
                end else begin
                  r_done      <= 1'b1;
                  r_char_idx  <= '0;
                  r_delay_cnt <= '0;
                  r_state     <= repeat_i ? S_DELAY : S_IDLE;
                end
              end
              default: ;
            endcase
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        S_DELAY: begin
          if (r_delay_cnt == c_delay_w'(DELAY_CYCLES - 1)) begin
            r_delay_cnt <= '0;
            r_state     <= repeat_i ? S_LOAD_TX : S_IDLE;
          end else begin
            r_delay_cnt <= r_delay_cnt + 1'b1;
          end
        end
        S_ERROR: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb.cyc_o  = r_cyc;
  assign wb.stb_o  = r_stb;
  assign wb.we_o   = r_we;
  assign wb.addr_o = r_addr;
  assign wb.dat_o  = r_dat;
  assign wb.sel_o  = 4'hF;
  assign wb.lock_o = 1'b0;
  assign wb.tagn_o = 1'b0;

  assign busy_o     = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign error_o    = (r_state == S_ERROR);
  assign done_o     = r_done;
  assign char_idx_o = r_char_idx;
  assign out_led    = r_led;

endmodule
`default_nettype wire
